// File: rtl/npe_vec_reduce_pkg.sv
// Shared encodings for the NPE vector reduction engine: reduction modes, FSM states
// and a small elaboration-time width helper.
package npe_vec_reduce_pkg;

   localparam logic [1:0] NPE_MODE_MAC = 2'd0;
   localparam logic [1:0] NPE_MODE_MAX = 2'd1;
   localparam logic [1:0] NPE_MODE_ACC = 2'd2;
   localparam logic [1:0] NPE_MODE_SQR = 2'd3;

   localparam logic [1:0] NPE_ST_IDLE  = 2'd0;
   localparam logic [1:0] NPE_ST_RUN   = 2'd1;
   localparam logic [1:0] NPE_ST_OUT   = 2'd2;

   function automatic int unsigned max_width(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/npe_vec_reduce_lane.sv
// One reduction lane: operand select, signed multiply, saturating add or running max,
// accumulator register and sticky saturation flag.
module npe_reduce_lane
   import npe_vec_reduce_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_clear,
   input  logic                  i_init,
   input  logic                  i_accept,
   input  logic [1:0]            i_mode,
   input  logic [DATA_WIDTH-1:0] i_m,
   input  logic [DATA_WIDTH-1:0] i_w,
   output logic [ACC_WIDTH-1:0]  o_acc,
   output logic                  o_sat
);

   localparam int PW = 2 * DATA_WIDTH;
   localparam int SW = int'(max_width(ACC_WIDTH, PW)) + 1;

   // Clamp limits carried at the widened sum width so the compare sees the true sum.
   localparam logic signed [SW-1:0] SUM_MAX = {{(SW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0] SUM_MIN = {{(SW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
   localparam logic [ACC_WIDTH-1:0] MAX_INIT = {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   logic signed [PW-1:0]        opa_s;
   logic signed [PW-1:0]        opb_s;
   logic signed [PW-1:0]        prod_s;
   logic signed [SW-1:0]        term_s;
   logic signed [SW-1:0]        sum_s;
   logic signed [ACC_WIDTH-1:0] m_ext_s;
   logic [ACC_WIDTH-1:0]        sat_val_s;
   logic                        sat_hit_s;

   logic [ACC_WIDTH-1:0]        acc_q, acc_d;
   logic                        sat_q, sat_d;

   // Operand selection, product and clamped sum for the additive modes
   always_comb begin
      opa_s   = {{DATA_WIDTH{i_m[DATA_WIDTH-1]}}, i_m};
      m_ext_s = {{(ACC_WIDTH-DATA_WIDTH){i_m[DATA_WIDTH-1]}}, i_m};
      if (i_mode == NPE_MODE_MAC) begin
         opb_s = {{DATA_WIDTH{i_w[DATA_WIDTH-1]}}, i_w};
      end else begin
         opb_s = opa_s;
      end
      prod_s = opa_s * opb_s;
      case (i_mode)
         NPE_MODE_MAC,
         NPE_MODE_SQR: term_s = {{(SW-PW){prod_s[PW-1]}}, prod_s};
         NPE_MODE_ACC: term_s = {{(SW-DATA_WIDTH){i_m[DATA_WIDTH-1]}}, i_m};
         default:      term_s = {SW{1'b0}};
      endcase
      sum_s = {{(SW-ACC_WIDTH){acc_q[ACC_WIDTH-1]}}, acc_q} + term_s;
      if (sum_s > SUM_MAX) begin
         sat_val_s = SUM_MAX[ACC_WIDTH-1:0];
         sat_hit_s = 1'b1;
      end else if (sum_s < SUM_MIN) begin
         sat_val_s = SUM_MIN[ACC_WIDTH-1:0];
         sat_hit_s = 1'b1;
      end else begin
         sat_val_s = sum_s[ACC_WIDTH-1:0];
         sat_hit_s = 1'b0;
      end
   end

   // Accumulator next state: abort, window init, beat update or hold
   always_comb begin
      acc_d = acc_q;
      sat_d = sat_q;
      if (i_clear) begin
         acc_d = {ACC_WIDTH{1'b0}};
         sat_d = 1'b0;
      end else if (i_init) begin
         acc_d = (i_mode == NPE_MODE_MAX) ? MAX_INIT : {ACC_WIDTH{1'b0}};
         sat_d = 1'b0;
      end else if (i_accept) begin
         if (i_mode == NPE_MODE_MAX) begin
            if (m_ext_s > $signed(acc_q)) begin
               acc_d = m_ext_s;
            end else begin
               acc_d = acc_q;
            end
         end else begin
            acc_d = sat_val_s;
            sat_d = sat_q | sat_hit_s;
         end
      end else begin
         acc_d = acc_q;
      end
   end

   // Accumulator and sticky flag registers
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         acc_q <= {ACC_WIDTH{1'b0}};
         sat_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         sat_q <= sat_d;
      end
   end

   assign o_acc = acc_q;
   assign o_sat = sat_q;

endmodule

// File: rtl/npe_vec_reduce.sv
// NPE vector reduction engine: window FSM and beat counter driving DATA_COPIES
// independent reduction lanes with input and output handshakes.
module npe_vec_reduce
   import npe_vec_reduce_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int DATA_COPIES = 32,
   parameter int ACC_WIDTH   = 16,
   parameter int LEN_WIDTH   = 10
) (
   input  logic                              i_clk,
   input  logic                              i_rst_n,
   input  logic                              i_clear,
   input  logic                              i_start,
   input  logic [1:0]                        i_mode,
   input  logic [LEN_WIDTH-1:0]              i_len,
   input  logic [DATA_COPIES*DATA_WIDTH-1:0] i_mdata,
   input  logic                              i_mdata_vld,
   input  logic [DATA_COPIES*DATA_WIDTH-1:0] i_wdata,
   input  logic                              i_wdata_vld,
   output logic                              o_in_rdy,
   output logic                              o_busy,
   output logic [DATA_COPIES*ACC_WIDTH-1:0]  o_result,
   output logic                              o_result_vld,
   input  logic                              i_result_rdy,
   output logic                              o_overflow
);

   localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]             state_q, state_d;
   logic [1:0]             mode_q, mode_d;
   logic [LEN_WIDTH-1:0]   len_q, len_d;
   logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   in_rdy_q, busy_q, vld_q;

   logic                   init_s;
   logic                   accept_s;
   logic                   last_s;
   logic [1:0]             lane_mode_s;
   logic [DATA_COPIES-1:0] lane_sat_s;

   // In IDLE the lanes need the incoming mode to pick their init value
   always_comb begin
      init_s      = (state_q == NPE_ST_IDLE) && i_start;
      accept_s    = (state_q == NPE_ST_RUN) && i_mdata_vld &&
                    ((mode_q != NPE_MODE_MAC) || i_wdata_vld);
      last_s      = accept_s && (cnt_q == (len_q - LEN_ONE));
      lane_mode_s = (state_q == NPE_ST_IDLE) ? i_mode : mode_q;
   end

   // Window FSM, latched parameters and beat counter
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      if (i_clear) begin
         state_d = NPE_ST_IDLE;
         cnt_d   = {LEN_WIDTH{1'b0}};
      end else begin
         case (state_q)
            NPE_ST_IDLE: begin
               if (i_start) begin
                  state_d = NPE_ST_RUN;
                  mode_d  = i_mode;
                  len_d   = (i_len == {LEN_WIDTH{1'b0}}) ? LEN_ONE : i_len;
                  cnt_d   = {LEN_WIDTH{1'b0}};
               end else begin
                  state_d = NPE_ST_IDLE;
               end
            end
            NPE_ST_RUN: begin
               if (last_s) begin
                  state_d = NPE_ST_OUT;
               end else if (accept_s) begin
                  cnt_d = cnt_q + LEN_ONE;
               end else begin
                  state_d = NPE_ST_RUN;
               end
            end
            NPE_ST_OUT: begin
               if (i_result_rdy) begin
                  state_d = NPE_ST_IDLE;
               end else begin
                  state_d = NPE_ST_OUT;
               end
            end
            default: state_d = NPE_ST_IDLE;
         endcase
      end
   end

   // Control registers; status outputs registered from the next state
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q  <= NPE_ST_IDLE;
         mode_q   <= NPE_MODE_MAC;
         len_q    <= LEN_ONE;
         cnt_q    <= {LEN_WIDTH{1'b0}};
         in_rdy_q <= 1'b0;
         busy_q   <= 1'b0;
         vld_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         in_rdy_q <= (state_d == NPE_ST_RUN);
         busy_q   <= (state_d != NPE_ST_IDLE);
         vld_q    <= (state_d == NPE_ST_OUT);
      end
   end

   for (genvar k = 0; k < DATA_COPIES; k++) begin : g_lane
      npe_reduce_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .ACC_WIDTH  (ACC_WIDTH)
      ) u_lane (
         .i_clk    (i_clk),
         .i_rst_n  (i_rst_n),
         .i_clear  (i_clear),
         .i_init   (init_s),
         .i_accept (accept_s),
         .i_mode   (lane_mode_s),
         .i_m      (i_mdata[k*DATA_WIDTH +: DATA_WIDTH]),
         .i_w      (i_wdata[k*DATA_WIDTH +: DATA_WIDTH]),
         .o_acc    (o_result[k*ACC_WIDTH +: ACC_WIDTH]),
         .o_sat    (lane_sat_s[k])
      );
   end

   assign o_in_rdy     = in_rdy_q;
   assign o_busy       = busy_q;
   assign o_result_vld = vld_q;
   assign o_overflow   = |lane_sat_s;

endmodule

// File: tb/tb_npe_vec_reduce.sv
// Directed bench for npe_vec_reduce: an arithmetic reference model checked every cycle
// plus hand-computed literal expectations per scenario.
module tb_npe_vec_reduce;

   localparam int DW = 8;
   localparam int NL = 32;
   localparam int AW = 16;
   localparam int LW = 10;
   localparam int AMAX = (1 << (AW-1)) - 1;
   localparam int AMIN = -(1 << (AW-1));

   logic              clk;
   logic              rst_n;
   logic              clear;
   logic              start;
   logic [1:0]        mode;
   logic [LW-1:0]     len;
   logic [NL*DW-1:0]  mdata;
   logic              mdata_vld;
   logic [NL*DW-1:0]  wdata;
   logic              wdata_vld;
   logic              in_rdy;
   logic              busy;
   logic [NL*AW-1:0]  result;
   logic              result_vld;
   logic              result_rdy;
   logic              overflow;

   int errors;
   int checks;

   npe_vec_reduce #(
      .DATA_WIDTH (DW),
      .DATA_COPIES(NL),
      .ACC_WIDTH  (AW),
      .LEN_WIDTH  (LW)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_clear     (clear),
      .i_start     (start),
      .i_mode      (mode),
      .i_len       (len),
      .i_mdata     (mdata),
      .i_mdata_vld (mdata_vld),
      .i_wdata     (wdata),
      .i_wdata_vld (wdata_vld),
      .o_in_rdy    (in_rdy),
      .o_busy      (busy),
      .o_result    (result),
      .o_result_vld(result_vld),
      .i_result_rdy(result_rdy),
      .o_overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: window phase (0 idle, 1 collecting, 2 holding result)
   int m_phase;
   int m_mode;
   int m_len;
   int m_cnt;
   int m_acc[NL];
   bit m_ovf;

   initial begin
      m_phase = 0; m_mode = 0; m_len = 1; m_cnt = 0; m_ovf = 1'b0;
      for (int k = 0; k < NL; k++) m_acc[k] = 0;
   end

   always @(posedge clk) begin
      if (!rst_n || clear) begin
         m_phase <= 0;
         m_ovf   <= 1'b0;
         for (int k = 0; k < NL; k++) m_acc[k] <= 0;
      end else if (m_phase == 0) begin
         if (start) begin
            m_phase <= 1;
            m_mode  <= int'(mode);
            m_len   <= (len == '0) ? 1 : int'(len);
            m_cnt   <= 0;
            m_ovf   <= 1'b0;
            for (int k = 0; k < NL; k++) m_acc[k] <= (mode == 2'd1) ? -(1 << (DW-1)) : 0;
         end
      end else if (m_phase == 1) begin
         if (mdata_vld && (m_mode != 0 || wdata_vld)) begin
            bit ovf_n;
            ovf_n = m_ovf;
            for (int k = 0; k < NL; k++) begin
               int mv, wv, s;
               mv = int'($signed(mdata[k*DW +: DW]));
               wv = int'($signed(wdata[k*DW +: DW]));
               if (m_mode == 1) begin
                  s = (mv > m_acc[k]) ? mv : m_acc[k];
               end else begin
                  s = m_acc[k] + ((m_mode == 0) ? mv * wv : (m_mode == 3) ? mv * mv : mv);
                  if (s > AMAX) begin s = AMAX; ovf_n = 1'b1; end
                  if (s < AMIN) begin s = AMIN; ovf_n = 1'b1; end
               end
               m_acc[k] <= s;
            end
            m_ovf <= ovf_n;
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 >= m_len) m_phase <= 2;
         end
      end else begin
         if (result_rdy) m_phase <= 0;
      end
   end

   task automatic check_bit(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
      end
   endtask

   task automatic check_lane(input string name, input int k, input logic [AW-1:0] exp);
      logic [AW-1:0] got;
      got = result[k*AW +: AW];
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: lane %0d got %h expected %h at %0t", name, k, got, exp, $time);
      end
   endtask

   // Per-cycle comparison of every meaningful output against the model
   task automatic compare_all();
      logic [NL*AW-1:0] exp_vec;
      for (int k = 0; k < NL; k++) exp_vec[k*AW +: AW] = m_acc[k][AW-1:0];
      check_bit("in_rdy", in_rdy, m_phase == 1);
      check_bit("busy", busy, m_phase != 0);
      check_bit("result_vld", result_vld, m_phase == 2);
      check_bit("overflow", overflow, m_ovf);
      if (m_phase != 1) begin
         checks++;
         if (result !== exp_vec) begin
            errors++;
            $display("FAIL result: got %h expected %h at %0t", result, exp_vec, $time);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      compare_all();
   endtask

   task automatic fill(input logic [DW-1:0] m, input logic [DW-1:0] w);
      for (int k = 0; k < NL; k++) begin
         mdata[k*DW +: DW] = m;
         wdata[k*DW +: DW] = w;
      end
   endtask

   task automatic start_win(input logic [1:0] md, input int ln);
      start = 1'b1; mode = md; len = LW'(ln);
      tick();
      start = 1'b0;
   endtask

   task automatic beats(input int n);
      mdata_vld = 1'b1; wdata_vld = 1'b1;
      repeat (n) tick();
      mdata_vld = 1'b0; wdata_vld = 1'b0;
   endtask

   task automatic handshake();
      result_rdy = 1'b1;
      tick();
      result_rdy = 1'b0;
   endtask

   initial begin
      errors = 0; checks = 0;
      rst_n = 1'b0; clear = 1'b0; start = 1'b0; mode = 2'd0; len = '0;
      mdata = '0; wdata = '0; mdata_vld = 1'b0; wdata_vld = 1'b0; result_rdy = 1'b0;
      tick(); tick();
      check_lane("reset_result", 0, 16'h0000);
      check_bit("reset_overflow", overflow, 1'b0);
      rst_n = 1'b1;
      tick();

      // MAC, len 4, 3*2 per beat
      fill(8'd3, 8'd2);
      start_win(2'd0, 4);
      beats(4);
      check_bit("mac_vld", result_vld, 1'b1);
      check_lane("mac_l0", 0, 16'd24);
      check_lane("mac_l31", 31, 16'd24);
      check_bit("mac_ovf", overflow, 1'b0);
      handshake();

      // MAX with per-lane sequences, then a 10-cycle stall with start ignored
      start_win(2'd1, 3);
      mdata = '0; mdata[0 +: DW] = 8'hFB; mdata[DW +: DW] = 8'h80;
      beats(1);
      mdata[0 +: DW] = 8'h07;
      beats(1);
      mdata[0 +: DW] = 8'h80;
      beats(1);
      check_lane("max_l0", 0, 16'h0007);
      check_lane("max_l1", 1, 16'hFF80);
      check_lane("max_l2", 2, 16'h0000);
      start = 1'b1;
      repeat (10) begin
         tick();
         check_lane("hold_l0", 0, 16'h0007);
         check_bit("hold_in_rdy", in_rdy, 1'b0);
      end
      start = 1'b0;
      handshake();
      check_bit("hold_idle", busy, 1'b0);
      check_lane("after_hs_l1", 1, 16'hFF80);

      // ACC, len 300 of 127 saturates positive
      fill(8'd127, 8'd0);
      start_win(2'd2, 300);
      begin
         bit done;
         done = 1'b0;
         mdata_vld = 1'b1;
         for (int i = 0; i < 400 && !done; i++) begin
            tick();
            if (result_vld) done = 1'b1;
         end
         mdata_vld = 1'b0;
         checks++;
         if (!done) begin
            errors++;
            $display("FAIL acc_timeout: got no result_vld expected result within 400 cycles");
         end
      end
      check_lane("acc_sat", 5, 16'h7FFF);
      check_bit("acc_ovf", overflow, 1'b1);
      handshake();
      check_bit("ovf_kept_idle", overflow, 1'b1);

      // SQR of -4 over 2 beats
      fill(8'hFC, 8'd0);
      start_win(2'd3, 2);
      check_bit("start_clears_ovf", overflow, 1'b0);
      beats(2);
      check_lane("sqr", 7, 16'd32);
      handshake();

      // MAC with weights missing every other cycle
      fill(8'd5, 8'd3);
      start_win(2'd0, 2);
      mdata_vld = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wdata_vld = (i % 2 == 1);
         tick();
         if (i == 2) check_bit("gap_not_done", result_vld, 1'b0);
      end
      mdata_vld = 1'b0; wdata_vld = 1'b0;
      check_lane("gap_mac", 3, 16'd30);
      handshake();

      // MAC negative saturation
      fill(8'h80, 8'h7F);
      start_win(2'd0, 3);
      beats(3);
      check_lane("neg_sat", 0, 16'h8000);
      check_bit("neg_ovf", overflow, 1'b1);
      handshake();

      // len 0 behaves as a single beat
      fill(8'd7, 8'd0);
      start_win(2'd2, 0);
      beats(1);
      check_bit("len0_vld", result_vld, 1'b1);
      check_lane("len0", 2, 16'd7);
      handshake();

      // Clear mid-window after a saturating beat
      fill(8'h80, 8'h7F);
      start_win(2'd0, 5);
      beats(3);
      check_bit("pre_clear_ovf", overflow, 1'b1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check_bit("clear_busy", busy, 1'b0);
      check_bit("clear_ovf", overflow, 1'b0);
      check_lane("clear_acc", 0, 16'h0000);

      // Reset while a result is pending, then a fresh window
      fill(8'd3, 8'd2);
      start_win(2'd0, 2);
      beats(2);
      check_lane("pre_rst", 0, 16'd12);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_bit("rst_vld", result_vld, 1'b0);
      check_lane("rst_acc", 0, 16'h0000);
      fill(8'hFC, 8'd0);
      start_win(2'd3, 1);
      beats(1);
      check_lane("post_rst_sqr", 9, 16'd16);
      handshake();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
